// File: rtl/tdm_mux8.sv
// 8-to-1 TDM serializer: snapshots eight lanes on start and emits each enabled lane for HOLD cycles.
// First slot appears one cycle after an accepted start; start is ignored while busy and is never queued.
module tdm_mux8 #(
  parameter int W    = 1,
  parameter int HOLD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [W-1:0] d4,
  input  logic [W-1:0] d5,
  input  logic [W-1:0] d6,
  input  logic [W-1:0] d7,
  input  logic [7:0]   lane_mask,
  input  logic         start,
  output logic [W-1:0] out,
  output logic         s0,
  output logic         s1,
  output logic         s2,
  output logic         out_valid,
  output logic         busy,
  output logic         frame_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t             state_q, state_d;
  logic [7:0][W-1:0]  snap_q, snap_d;
  logic [7:0]         mask_q, mask_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         hold_q, hold_d;

  logic [W-1:0]       out_q, out_d;
  logic [2:0]         sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic [3:0]         lane_first, lane_nxt, lane_after_d;

  // Returns {found, index} of the lowest enabled lane at or above 'from'.
  function automatic logic [3:0] next_lane(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      out_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    lane_first = next_lane(lane_mask, 4'd0);
    lane_nxt   = next_lane(mask_q, {1'b0, idx_q} + 4'd1);
    case (state_q)
      IDLE: begin
        if (start && (lane_mask != 8'd0)) begin
          state_d = SCAN;
          snap_d  = {d7, d6, d5, d4, d3, d2, d1, d0};
          mask_d  = lane_mask;
          idx_d   = lane_first[2:0];
          hold_d  = 8'd0;
        end
      end
      SCAN: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = 8'd0;
          if (lane_nxt[3]) begin
            idx_d = lane_nxt[2:0];
          end else begin
            state_d = IDLE;
            idx_d   = 3'd0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered images of the next state, so they line up with the slot being entered.
  always_comb begin
    out_d        = '0;
    sel_d        = 3'd0;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    lane_after_d = next_lane(mask_d, {1'b0, idx_d} + 4'd1);
    if (state_d == SCAN) begin
      out_d   = snap_d[idx_d];
      sel_d   = idx_d;
      valid_d = 1'b1;
      done_d  = (hold_d == HOLD_LAST) && !lane_after_d[3];
    end
  end

  assign out        = out_q;
  assign s0         = sel_q[0];
  assign s1         = sel_q[1];
  assign s2         = sel_q[2];
  assign out_valid  = valid_q;
  assign busy       = valid_q;
  assign frame_done = done_q;

endmodule
